// File: rtl/store_align_if.sv
// Store request and memory write bus for store_align_unit.
// slave = the store unit; master = the requester/memory side.
interface store_align_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_op;
  logic [DATA_W-1:0] req_wdata;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              done;
  logic              err;

  modport slave (
    input  req_valid, req_addr, req_op, req_wdata, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_be, mem_wdata, done, err
  );

  modport master (
    output req_valid, req_addr, req_op, req_wdata, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_be, mem_wdata, done, err
  );
endinterface

// File: rtl/store_align_unit.sv
// Lane-aligns byte/half/word/dword stores onto the memory write bus.
// Macro MISALIGN_SPLIT_EN: split boundary-crossing stores into two beats (otherwise they error).
module store_align_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input logic          clk,
  input logic          rst_n,
  store_align_if.slave bus
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned BE2_W = 2 * BE_W;
  localparam int unsigned DW2_W = 2 * DATA_W;
  localparam int unsigned SUM_W = OFF_W + 2;

`ifdef MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, RESP = 2'd2, BEAT1 = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, RESP = 2'd2} state_t;
`endif

  state_t state;

  // Byte enables across two adjacent beats: low half is the first beat, high half the second.
  function automatic logic [BE2_W-1:0] lane_be(input logic [OFF_W-1:0] off, input logic [1:0] op);
    logic [8:0] mask;
    mask = (9'd1 << (4'd1 << op)) - 9'd1;
    return BE2_W'(mask) << off;
  endfunction

  function automatic logic [DW2_W-1:0] lane_data(input logic [OFF_W-1:0] off,
                                                 input logic [DATA_W-1:0] wd);
    return DW2_W'(wd) << {off, 3'b000};
  endfunction

  logic [OFF_W-1:0]  req_off;
  logic [3:0]        req_size;
  logic              req_cross;
  logic              req_illegal;
  logic              req_reject;
  logic [BE_W-1:0]   req_be_lo;
  logic [DATA_W-1:0] req_data_lo;
  logic [ADDR_W-1:0] req_base;

  always_comb begin
    req_off     = bus.req_addr[OFF_W-1:0];
    req_size    = 4'd1 << bus.req_op;
    req_cross   = (SUM_W'(req_off) + SUM_W'(req_size)) > SUM_W'(BE_W);
    req_illegal = (DATA_W == 32) && (bus.req_op == 2'b11);
    req_be_lo   = BE_W'(lane_be(req_off, bus.req_op));
    req_data_lo = DATA_W'(lane_data(req_off, bus.req_wdata));
    req_base    = {bus.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
  end

`ifdef MISALIGN_SPLIT_EN
  logic [OFF_W-1:0]  off_q;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] wdata_q;
  logic              cross_q;
  logic [BE_W-1:0]   hold_be_hi;
  logic [DATA_W-1:0] hold_data_hi;

  assign req_reject = req_illegal;

  // Second-beat lanes come from the captured request, not the live inputs.
  always_comb begin
    hold_be_hi   = BE_W'(lane_be(off_q, op_q) >> BE_W);
    hold_data_hi = DATA_W'(lane_data(off_q, wdata_q) >> DATA_W);
  end
`else
  assign req_reject = req_illegal || req_cross;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.req_ready <= 1'b1;
      bus.mem_valid <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
      off_q         <= '0;
      op_q          <= '0;
      wdata_q       <= '0;
      cross_q       <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            off_q   <= req_off;
            op_q    <= bus.req_op;
            wdata_q <= bus.req_wdata;
            cross_q <= req_cross;
`endif
            if (req_reject) begin
              state   <= RESP;
              bus.err <= 1'b1;
            end else begin
              state         <= BEAT0;
              bus.mem_valid <= 1'b1;
              bus.mem_addr  <= req_base;
              bus.mem_be    <= req_be_lo;
              bus.mem_wdata <= req_data_lo;
            end
          end
        end
        BEAT0: begin
          if (bus.mem_ready) begin
`ifdef MISALIGN_SPLIT_EN
            if (cross_q) begin
              state         <= BEAT1;
              bus.mem_addr  <= bus.mem_addr + ADDR_W'(BE_W);
              bus.mem_be    <= hold_be_hi;
              bus.mem_wdata <= hold_data_hi;
            end else
`endif
            begin
              state         <= RESP;
              bus.mem_valid <= 1'b0;
              bus.mem_be    <= '0;
              bus.done      <= 1'b1;
            end
          end
        end
`ifdef MISALIGN_SPLIT_EN
        BEAT1: begin
          if (bus.mem_ready) begin
            state         <= RESP;
            bus.mem_valid <= 1'b0;
            bus.mem_be    <= '0;
            bus.done      <= 1'b1;
          end
        end
`endif
        RESP: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_store_align_unit.sv
// Directed self-checking bench for store_align_unit (DATA_W=32, ADDR_W=32).
// Split-store scenarios follow MISALIGN_SPLIT_EN; without it those stores must error.
module tb_store_align_unit;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  store_align_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  store_align_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Present one request for a single cycle; returns at the negedge after acceptance.
  task automatic send(input logic [31:0] addr, input logic [1:0] op, input logic [31:0] wd);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_op    = op;
    bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({bus.req_ready, bus.mem_valid, bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.done, bus.err}
        !== {1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0})
      $display("FAIL reset: got rdy=%b v=%b a=%h be=%b d=%h done=%b err=%b want rdy=1 others 0",
               bus.req_ready, bus.mem_valid, bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.done, bus.err);
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_single(input string nm, input logic [31:0] addr, input logic [1:0] op,
                             input logic [31:0] wd, input logic [31:0] ea, input logic [3:0] eb,
                             input logic [31:0] ed);
    send(addr, op, wd);
    total_cnt++;
    if ({bus.mem_valid, bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.req_ready, bus.done}
        !== {1'b1, ea, eb, ed, 1'b0, 1'b0})
      $display("FAIL %s beat: got v=%b a=%h be=%b d=%h rdy=%b done=%b want v=1 a=%h be=%b d=%h rdy=0 done=0",
               nm, bus.mem_valid, bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.req_ready, bus.done, ea, eb, ed);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({bus.done, bus.err, bus.mem_valid, bus.mem_be} !== {1'b1, 1'b0, 1'b0, 4'h0})
      $display("FAIL %s resp: got done=%b err=%b v=%b be=%b want done=1 err=0 v=0 be=0000",
               nm, bus.done, bus.err, bus.mem_valid, bus.mem_be);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({bus.done, bus.req_ready} !== 2'b01)
      $display("FAIL %s idle: got done=%b rdy=%b want done=0 rdy=1", nm, bus.done, bus.req_ready);
    else pass_cnt++;
  endtask

`ifdef MISALIGN_SPLIT_EN
  task automatic test_split(input string nm, input logic [31:0] addr, input logic [1:0] op,
                            input logic [31:0] wd,
                            input logic [31:0] a0, input logic [3:0] b0, input logic [31:0] d0,
                            input logic [31:0] a1, input logic [3:0] b1, input logic [31:0] d1);
    send(addr, op, wd);
    total_cnt++;
    if ({bus.mem_valid, bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.done} !== {1'b1, a0, b0, d0, 1'b0})
      $display("FAIL %s beat0: got v=%b a=%h be=%b d=%h done=%b want v=1 a=%h be=%b d=%h done=0",
               nm, bus.mem_valid, bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.done, a0, b0, d0);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({bus.mem_valid, bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.done} !== {1'b1, a1, b1, d1, 1'b0})
      $display("FAIL %s beat1: got v=%b a=%h be=%b d=%h done=%b want v=1 a=%h be=%b d=%h done=0",
               nm, bus.mem_valid, bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.done, a1, b1, d1);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({bus.done, bus.err, bus.mem_valid} !== 3'b100)
      $display("FAIL %s resp: got done=%b err=%b v=%b want done=1 err=0 v=0",
               nm, bus.done, bus.err, bus.mem_valid);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({bus.done, bus.req_ready} !== 2'b01)
      $display("FAIL %s idle: got done=%b rdy=%b want done=0 rdy=1", nm, bus.done, bus.req_ready);
    else pass_cnt++;
  endtask
`endif

  task automatic test_reject(input string nm, input logic [31:0] addr, input logic [1:0] op,
                             input logic [31:0] wd);
    send(addr, op, wd);
    total_cnt++;
    if ({bus.err, bus.done, bus.mem_valid, bus.mem_be} !== {1'b1, 1'b0, 1'b0, 4'h0})
      $display("FAIL %s err: got err=%b done=%b v=%b be=%b want err=1 done=0 v=0 be=0000",
               nm, bus.err, bus.done, bus.mem_valid, bus.mem_be);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({bus.err, bus.done, bus.mem_valid, bus.req_ready} !== 4'b0001)
      $display("FAIL %s idle: got err=%b done=%b v=%b rdy=%b want err=0 done=0 v=0 rdy=1",
               nm, bus.err, bus.done, bus.mem_valid, bus.req_ready);
    else pass_cnt++;
  endtask

  // Memory stalls three cycles while a different request waits on the input.
  task automatic test_stall();
    bus.mem_ready = 1'b0;
    send(32'h6001, 2'b00, 32'h5A);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h7777_7777;
    bus.req_op    = 2'b10;
    bus.req_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      total_cnt++;
      if ({bus.mem_valid, bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.req_ready, bus.done}
          !== {1'b1, 32'h6000, 4'b0010, 32'h0000_5A00, 1'b0, 1'b0})
        $display("FAIL stall%0d: got v=%b a=%h be=%b d=%h rdy=%b done=%b want v=1 a=00006000 be=0010 d=00005a00 rdy=0 done=0",
                 i, bus.mem_valid, bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.req_ready, bus.done);
      else pass_cnt++;
    end
    bus.mem_ready = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({bus.done, bus.mem_valid} !== 2'b10)
      $display("FAIL stall_resp: got done=%b v=%b want done=1 v=0", bus.done, bus.mem_valid);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0100;
    bus.req_op    = 2'b10;
    bus.req_wdata = 32'h1111_1111;
    @(negedge clk);
    bus.req_addr  = 32'h0205;
    bus.req_op    = 2'b00;
    bus.req_wdata = 32'h22;
    total_cnt++;
    if ({bus.mem_valid, bus.mem_addr, bus.mem_be, bus.mem_wdata} !== {1'b1, 32'h0100, 4'b1111, 32'h1111_1111})
      $display("FAIL b2b_a: got v=%b a=%h be=%b d=%h want v=1 a=00000100 be=1111 d=11111111",
               bus.mem_valid, bus.mem_addr, bus.mem_be, bus.mem_wdata);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if ({bus.req_ready, bus.mem_valid, bus.done} !== 3'b100)
      $display("FAIL b2b_idle: got rdy=%b v=%b done=%b want rdy=1 v=0 done=0",
               bus.req_ready, bus.mem_valid, bus.done);
    else pass_cnt++;
    @(negedge clk);
    bus.req_valid = 1'b0;
    total_cnt++;
    if ({bus.mem_valid, bus.mem_addr, bus.mem_be, bus.mem_wdata} !== {1'b1, 32'h0204, 4'b0010, 32'h0000_2200})
      $display("FAIL b2b_b: got v=%b a=%h be=%b d=%h want v=1 a=00000204 be=0010 d=00002200",
               bus.mem_valid, bus.mem_addr, bus.mem_be, bus.mem_wdata);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Reset in the middle of a store, then a request on the first edge after release.
  task automatic test_reset_mid();
`ifdef MISALIGN_SPLIT_EN
    bus.mem_ready = 1'b1;
    send(32'h3002, 2'b10, 32'hDDCC_BBAA);
    @(negedge clk);
`else
    bus.mem_ready = 1'b0;
    send(32'h3000, 2'b10, 32'hDDCC_BBAA);
`endif
    total_cnt++;
    if (bus.mem_valid !== 1'b1)
      $display("FAIL rst_mid_pre: got v=%b want v=1", bus.mem_valid);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.mem_valid, bus.mem_be, bus.req_ready} !== {1'b0, 4'h0, 1'b1})
      $display("FAIL rst_mid_async: got v=%b be=%b rdy=%b want v=0 be=0000 rdy=1",
               bus.mem_valid, bus.mem_be, bus.req_ready);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({bus.done, bus.err, bus.mem_valid} !== 3'b000)
        $display("FAIL rst_mid_hold%0d: got done=%b err=%b v=%b want 0 0 0", i, bus.done, bus.err, bus.mem_valid);
      else pass_cnt++;
    end
    rst_n         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h9004;
    bus.req_op    = 2'b10;
    bus.req_wdata = 32'h0BAD_F00D;
    @(negedge clk);
    bus.req_valid = 1'b0;
    total_cnt++;
    if ({bus.mem_valid, bus.mem_addr, bus.mem_be, bus.mem_wdata} !== {1'b1, 32'h9004, 4'b1111, 32'h0BAD_F00D})
      $display("FAIL rst_mid_next: got v=%b a=%h be=%b d=%h want v=1 a=00009004 be=1111 d=0badf00d",
               bus.mem_valid, bus.mem_addr, bus.mem_be, bus.mem_wdata);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({bus.done, bus.err} !== 2'b10)
      $display("FAIL rst_mid_done: got done=%b err=%b want done=1 err=0", bus.done, bus.err);
    else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_op    = '0;
    bus.req_wdata = '0;
    bus.mem_ready = 1'b1;
    test_reset();
    test_single("byte_1003", 32'h1003, 2'b00, 32'h0000_00A5, 32'h1000, 4'b1000, 32'hA500_0000);
    test_single("half_2001", 32'h2001, 2'b01, 32'h0000_1234, 32'h2000, 4'b0110, 32'h0012_3400);
    test_single("half_8002", 32'h8002, 2'b01, 32'h0000_BEEF, 32'h8000, 4'b1100, 32'hBEEF_0000);
    test_single("word_4000", 32'h4000, 2'b10, 32'hCAFE_F00D, 32'h4000, 4'b1111, 32'hCAFE_F00D);
    test_single("byte_0010", 32'h0010, 2'b00, 32'h1234_5678, 32'h0010, 4'b0001, 32'h1234_5678);
`ifdef MISALIGN_SPLIT_EN
    test_split("word_3002", 32'h3002, 2'b10, 32'hDDCC_BBAA,
               32'h3000, 4'b1100, 32'hBBAA_0000, 32'h3004, 4'b0011, 32'h0000_DDCC);
    test_split("half_8003", 32'h8003, 2'b01, 32'h0000_BEEF,
               32'h8000, 4'b1000, 32'hEF00_0000, 32'h8004, 4'b0001, 32'h0000_00BE);
    test_split("word_wrap", 32'hFFFF_FFFE, 2'b10, 32'h4433_2211,
               32'hFFFF_FFFC, 4'b1100, 32'h2211_0000, 32'h0000_0000, 4'b0011, 32'h0000_4433);
`else
    test_reject("word_3002", 32'h3002, 2'b10, 32'hDDCC_BBAA);
    test_reject("half_8003", 32'h8003, 2'b01, 32'h0000_BEEF);
`endif
    test_reject("dword_5000", 32'h5000, 2'b11, 32'h0000_0001);
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/store_align_unit.md
STORE_ALIGN_UNIT -- requirements
Module: store_align_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the memory bus data width in bits; legal values are 32 and 64.
REQ-002 The block SHALL have parameter ADDR_W, default 32, giving the byte-address width.
REQ-003 The block SHALL derive local parameters BE_W = DATA_W/8 and OFF_W = log2(BE_W).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: a store request is present.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the unit can accept a request.
REQ-008 The block SHALL have port req_addr, input, ADDR_W bits: store byte address.
REQ-009 The block SHALL have port req_op, input, 2 bits: store size, 00 byte, 01 half, 10 word, 11 dword.
REQ-010 The block SHALL have port req_wdata, input, DATA_W bits: store data, right-justified.
REQ-011 The block SHALL have port mem_valid, output, 1 bit: a bus write beat is valid.
REQ-012 The block SHALL have port mem_ready, input, 1 bit: memory accepts the beat.
REQ-013 The block SHALL have port mem_addr, output, ADDR_W bits: beat address, with the low OFF_W bits always zero.
REQ-014 The block SHALL have port mem_be, output, BE_W bits: per-byte write enables.
REQ-015 The block SHALL have port mem_wdata, output, DATA_W bits: lane-aligned write data.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle pulse signalling store completion.
REQ-017 The block SHALL have port err, output, 1 bit: one-cycle pulse signalling an illegal or unsupported store.

Function
REQ-018 The block SHALL implement FSM states IDLE, BEAT0, BEAT1 and RESP.
REQ-019 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted when req_valid && req_ready.
REQ-020 On acceptance, addr, op and wdata SHALL be registered, and the block SHALL not sample req_* again until it returns to IDLE.
REQ-021 Size S SHALL equal 1<<op bytes, offset o SHALL equal addr[OFF_W-1:0], and a store SHALL cross a boundary when o+S > BE_W.
REQ-022 op=11 with DATA_W=32 SHALL be illegal: the FSM goes IDLE->RESP with err=1 and issues no bus beat.
REQ-023 For a legal request, the FSM SHALL go IDLE->BEAT0, with mem_valid=1 in the cycle after acceptance.
REQ-024 In BEAT0, mem_addr SHALL be addr with the low OFF_W bits cleared, mem_be SHALL be ((1<<S)-1)<<o truncated to BE_W, and mem_wdata SHALL be wdata<<(8*o) truncated to DATA_W.
REQ-025 Misaligned stores that do not cross a boundary (e.g. a half at offset 1) SHALL complete in a single beat.
REQ-026 In BEAT1, mem_addr SHALL be the BEAT0 address + BE_W (wrapping modulo 2^ADDR_W), mem_be SHALL be ((1<<S)-1)>>(BE_W-o), and mem_wdata SHALL be wdata>>(8*(BE_W-o)).
REQ-027 In any beat state, mem_valid && !mem_ready SHALL hold mem_addr, mem_be and mem_wdata stable.
REQ-028 In BEAT0, mem_ready SHALL move the FSM to BEAT1 if the store crosses (REQ-029) or to RESP otherwise.
REQ-029 In BEAT1, mem_ready SHALL move the FSM to RESP.
REQ-030 RESP SHALL last exactly one cycle with done=1 (or err=1 on an error path), then return to IDLE; done and err SHALL never be 1 together.
REQ-031 Minimum latency SHALL be 3 cycles from acceptance to done for a single-beat store with mem_ready tied to 1, and 4 cycles for a split store.
REQ-032 Outside beat states, mem_valid SHALL be 0 and mem_be SHALL be all-zero.

Reset
REQ-033 While rst_n=0, the FSM SHALL be IDLE and outputs SHALL be: req_ready=1, mem_valid=0, mem_addr=0, mem_be=0, mem_wdata=0, done=0, err=0.
REQ-034 Reset assertion mid-operation (BEAT0, BEAT1 or RESP) SHALL drop mem_valid asynchronously and abandon the store with no done or err pulse.
REQ-035 The first request after rst_n deasserts SHALL be accepted on the first rising clk edge.

Configuration
REQ-036 With macro MISALIGN_SPLIT_EN defined, boundary-crossing stores SHALL be split into BEAT0 and BEAT1 as above.
REQ-037 With MISALIGN_SPLIT_EN undefined, a boundary-crossing store SHALL take IDLE->RESP with err=1 and no bus beat, and the BEAT1 state and logic SHALL be absent.

Verification
REQ-038 DATA_W=32, byte store, addr 0x1003, wdata 0xA5, mem_ready=1 -> one beat with mem_addr 0x1000, mem_be 1000, mem_wdata 0xA5000000; done 3 cycles after acceptance.
REQ-039 Half store, addr 0x2001, wdata 0x1234 -> single beat with mem_addr 0x2000, mem_be 0110, mem_wdata 0x00123400.
REQ-040 MISALIGN_SPLIT_EN defined, word store, addr 0x3002, wdata 0xDDCCBBAA -> beat 0x3000/1100/0xBBAA0000 then beat 0x3004/0011/0x0000DDCC, then done.
REQ-041 Same store with MISALIGN_SPLIT_EN undefined -> err pulse, mem_valid never 1; op=11 at DATA_W=32 -> err pulse, no bus beat.
REQ-042 mem_ready held 0 for 3 cycles in BEAT0 -> mem_* outputs constant across those cycles, and req_ready=0 throughout.
REQ-043 rst_n pulsed low during BEAT1 -> mem_valid=0 immediately, no done; the next request completes normally.
